id_stage_latched: RTL
=====================

Name: id_stage_latched

Overview:
- Parametrised next-generation decode stage for the pipelined MIPS core.
- Contains the register file (with write-back bypass), the HI/LO registers (with bypass), immediate extension, destination and jump-address selection, and the ID/EX pipeline latch with stall and flush.
- Sits between IF/ID and EX. Write-back and HI/LO writes enter from the WB stage.

Parameters:
- XLEN, 32, datapath width; must be at least 32 (IR fields and immediates are zero/sign-extended to XLEN).
- REG_AW, 5, register address width; NREG = 2**REG_AW registers.
- SYS_R1, 4, register read on port 1 when sys is high.
- SYS_R2, 2, register read on port 2 when sys is high.
- LINK_REG, 31, destination when jal is high; must be < NREG.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  32  instruction word from IF/ID.
- id_valid  in  1  ir holds a real instruction.
- sys  in  1  syscall: read registers SYS_R1/SYS_R2.
- unsigned_imm  in  1  1 = zero-extend imm16, 0 = sign-extend.
- reg_dst  in  1  1 = destination is rd, 0 = rt.
- jr  in  1  jump address comes from rd1.
- jal  in  1  destination is LINK_REG.
- stall  in  1  hold the ID/EX latch.
- flush  in  1  load a bubble into the ID/EX latch.
- wb_we  in  1  register-file write enable.
- wb_reg  in  REG_AW  write-back register number.
- wb_data  in  XLEN  write-back data.
- hi_we  in  1  HI write enable.
- hi_wdata  in  XLEN  HI write data.
- lo_we  in  1  LO write enable.
- lo_wdata  in  XLEN  LO write data.
- ex_valid  out  1  latched instruction valid.
- ex_rd1  out  XLEN  latched read data 1.
- ex_rd2  out  XLEN  latched read data 2.
- ex_imm  out  XLEN  latched extended immediate.
- ex_shamt  out  5  latched ir[10:6].
- ex_wbreg  out  REG_AW  latched destination register.
- ex_hi  out  XLEN  latched HI value.
- ex_lo  out  XLEN  latched LO value.
- ex_jaddr  out  XLEN  latched jump address.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All NREG registers, HI and LO clear to 0.
  - Every ex_* output clears to 0.
  - Takes effect immediately and overrides any concurrent write, stall or flush.
- Read addresses:
  - r1 = sys ? SYS_R1 : ir[25:21]; r2 = sys ? SYS_R2 : ir[20:16].
  - Field values are truncated or zero-extended to REG_AW.
- Register 0:
  - Always reads 0.
  - Writes to register 0 are ignored, and register 0 is never bypassed.
- Write-first bypass (combinational):
  - If wb_we=1, wb_reg=r and r!=0, a read of r in the same cycle returns wb_data; otherwise it returns the stored value.
  - The array itself updates at the rising edge.
- HI/LO:
  - Update at the rising edge when hi_we/lo_we are high.
  - Same-cycle bypass: the value captured into ex_hi is hi_wdata if hi_we=1, otherwise HI. LO behaves the same way.
- Immediate: imm = unsigned_imm ? zero-extend(ir[15:0]) : sign-extend(ir[15:0]), extended to XLEN.
- Destination: wbreg = jal ? LINK_REG : (reg_dst ? ir[15:11] : ir[20:16]).
- Jump address: jaddr = jr ? bypassed rd1 : zero-extend(ir[25:0]).
- ID/EX latch, one-cycle latency, priority flush > stall > load:
  - flush=1: ex_valid=0 and all ex_* fields = 0 at the next edge, even if stall=1.
  - stall=1 (flush=0): all ex_* outputs hold their values.
  - Otherwise: latch all computed fields, with ex_valid=id_valid. Fields are captured even when id_valid=0.
- Register-file, HI and LO writes proceed regardless of stall and flush.
- A stalled latch does not re-sample the bypass. EX-side forwarding covers any later write to a held source register.

Test Plan:
- Reset mid-operation: load x5=0x1234, pulse rst_n low mid-cycle → ex_* become 0 immediately; a later read of x5 returns 0.
- Bypass: wb_we=1, wb_reg=8, wb_data=0xDEADBEEF while ir reads rs=8 → ex_rd1=0xDEADBEEF at the next edge. The same write to reg 0 → ex_rd1=0.
- Immediate and destination:
  - ir imm=0x8000, unsigned_imm=0 → ex_imm=0xFFFF8000; unsigned_imm=1 → 0x00008000.
  - jal=1 → ex_wbreg=31; reg_dst=1, rd=12 → 12.
- Stall/flush priority:
  - stall=1 for 3 cycles while ir changes → ex_* unchanged.
  - stall=1 and flush=1 together → ex_valid=0, all fields 0.
- HI/LO and syscall:
  - hi_we=1, hi_wdata=0x55 in the same cycle as decode → ex_hi=0x55.
  - sys=1 with x4=7, x2=10 → ex_rd1=7, ex_rd2=10.
- Parametrised build: XLEN=64, REG_AW=6 → write x63 and read it back; sign extension fills bits 63:16.

Source files
------------

// File: rtl/id_stage_latched_if.sv
// Decode-stage bus: IF/ID decode inputs, WB-stage write ports and the
// ID/EX latch outputs, bundled so the stage and its environment agree on widths.
interface id_stage_latched_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    // decode side (from IF/ID and control)
    logic [31:0]       ir;
    logic              id_valid;
    logic              sys;
    logic              unsigned_imm;
    logic              reg_dst;
    logic              jr;
    logic              jal;
    logic              stall;
    logic              flush;

    // write-back side
    logic              wb_we;
    logic [REG_AW-1:0] wb_reg;
    logic [XLEN-1:0]   wb_data;
    logic              hi_we;
    logic [XLEN-1:0]   hi_wdata;
    logic              lo_we;
    logic [XLEN-1:0]   lo_wdata;

    // ID/EX latch
    logic              ex_valid;
    logic [XLEN-1:0]   ex_rd1;
    logic [XLEN-1:0]   ex_rd2;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_shamt;
    logic [REG_AW-1:0] ex_wbreg;
    logic [XLEN-1:0]   ex_hi;
    logic [XLEN-1:0]   ex_lo;
    logic [XLEN-1:0]   ex_jaddr;

    modport master (
        output ir, id_valid, sys, unsigned_imm, reg_dst, jr, jal, stall, flush,
        output wb_we, wb_reg, wb_data, hi_we, hi_wdata, lo_we, lo_wdata,
        input  ex_valid, ex_rd1, ex_rd2, ex_imm, ex_shamt, ex_wbreg,
        input  ex_hi, ex_lo, ex_jaddr
    );

    modport slave (
        input  ir, id_valid, sys, unsigned_imm, reg_dst, jr, jal, stall, flush,
        input  wb_we, wb_reg, wb_data, hi_we, hi_wdata, lo_we, lo_wdata,
        output ex_valid, ex_rd1, ex_rd2, ex_imm, ex_shamt, ex_wbreg,
        output ex_hi, ex_lo, ex_jaddr
    );
endinterface

// File: rtl/id_stage_latched.sv
// MIPS decode stage: register file and HI/LO with write-first bypass,
// immediate extension, destination / jump-address selection and the
// ID/EX latch (flush beats stall beats load).
module id_stage_latched #(
    parameter int XLEN     = 32,  // >= 32
    parameter int REG_AW   = 5,
    parameter int SYS_R1   = 4,
    parameter int SYS_R2   = 2,
    parameter int LINK_REG = 31   // < 2**REG_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    id_stage_latched_if.slave  bus
);
    localparam int NREG = 2 ** REG_AW;

    typedef logic [REG_AW-1:0] ra_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      shamt;
        ra_t             wbreg;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] jaddr;
    } ex_t;

    // IR register fields are 5 bits; fit them to the register address width
    function automatic ra_t fit_reg(input logic [4:0] f);
        return ra_t'(f);
    endfunction

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    ex_t             ex_d;
    ex_t             ex_q;
    ra_t             r1;
    ra_t             r2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    // opcode bits are decoded upstream into the control inputs
    logic unused_opcode;
    assign unused_opcode = ^bus.ir[31:26];

    assign r1 = bus.sys ? ra_t'(SYS_R1) : fit_reg(bus.ir[25:21]);
    assign r2 = bus.sys ? ra_t'(SYS_R2) : fit_reg(bus.ir[20:16]);

    // register array; entry 0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.wb_we && bus.wb_reg != '0) begin
            regs[bus.wb_reg] <= bus.wb_data;
        end
    end

    // HI/LO update independently of stall/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (bus.hi_we) hi_q <= bus.hi_wdata;
            if (bus.lo_we) lo_q <= bus.lo_wdata;
        end
    end

    // read port 1: r0 is hard zero, otherwise write-first bypass
    always_comb begin
        rd1 = '0;
        if (r1 != '0) begin
            if (bus.wb_we && bus.wb_reg == r1) rd1 = bus.wb_data;
            else                               rd1 = regs[r1];
        end
    end

    // read port 2: same rules as port 1
    always_comb begin
        rd2 = '0;
        if (r2 != '0) begin
            if (bus.wb_we && bus.wb_reg == r2) rd2 = bus.wb_data;
            else                               rd2 = regs[r2];
        end
    end

    // next ID/EX contents; fields are built even for invalid instructions
    always_comb begin
        ex_d       = '0;
        ex_d.valid = bus.id_valid;
        ex_d.rd1   = rd1;
        ex_d.rd2   = rd2;
        ex_d.shamt = bus.ir[10:6];
        ex_d.hi    = bus.hi_we ? bus.hi_wdata : hi_q;
        ex_d.lo    = bus.lo_we ? bus.lo_wdata : lo_q;
        if (bus.unsigned_imm) ex_d.imm = XLEN'(bus.ir[15:0]);
        else                  ex_d.imm = {{(XLEN-16){bus.ir[15]}}, bus.ir[15:0]};
        if (bus.jal)          ex_d.wbreg = ra_t'(LINK_REG);
        else if (bus.reg_dst) ex_d.wbreg = fit_reg(bus.ir[15:11]);
        else                  ex_d.wbreg = fit_reg(bus.ir[20:16]);
        ex_d.jaddr = bus.jr ? rd1 : XLEN'(bus.ir[25:0]);
    end

    // ID/EX latch: a held latch keeps its captured (bypassed) operands;
    // later writes to those sources are handled by EX forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ex_q <= '0;
        else if (bus.flush)  ex_q <= '0;
        else if (!bus.stall) ex_q <= ex_d;
    end

    assign bus.ex_valid = ex_q.valid;
    assign bus.ex_rd1   = ex_q.rd1;
    assign bus.ex_rd2   = ex_q.rd2;
    assign bus.ex_imm   = ex_q.imm;
    assign bus.ex_shamt = ex_q.shamt;
    assign bus.ex_wbreg = ex_q.wbreg;
    assign bus.ex_hi    = ex_q.hi;
    assign bus.ex_lo    = ex_q.lo;
    assign bus.ex_jaddr = ex_q.jaddr;

endmodule
